mips_store_buffer: RTL and testbench
====================================

// Module: mips_store_buffer
// PURPOSE
//   Posted-write store buffer between the single-cycle MIPS core data port (memwrite/dataadr/writedata)
//   and data memory. Core stores are queued and drained to memory when it is ready, so slow memory
//   does not stall the core. Loads forward from buffered stores. A flush handshake empties the buffer
//   before end-of-test checks.
// PARAMETERS
//   DEPTH  4   entries; power of two, >=2
//   AW     32  address width (word compare uses [AW-1:2])
//   DW     32  data width
// PORTS
//   clk         in   1   sole clock; rising edge
//   reset       in   1   asynchronous, active-low reset
//   memwrite    in   1   core store request this cycle
//   dataadr     in   AW  core load/store byte address; [1:0] ignored (word-only)
//   writedata   in   DW  core store data
//   readdata    out  DW  load data to core: forwarded buffer data or mem_rdata
//   stall       out  1   core must hold PC/instr; store not accepted this cycle
//   flush       in   1   level request: drain buffer, block new stores
//   flush_done  out  1   one-cycle pulse when flush completes
//   empty       out  1   buffer holds no entries
//   mem_we      out  1   head entry valid toward memory
//   mem_addr    out  AW  head entry address
//   mem_wdata   out  DW  head entry data
//   mem_ready   in   1   memory accepts head this cycle
//   mem_rdata   in   DW  memory combinational read data at dataadr
// BEHAVIOUR
//   Reset (async, reset==0): head=tail=0, count=0, state=RUN. Outputs: mem_we=0, stall=0, empty=1,
//     flush_done=0. readdata follows mem_rdata. Entry contents are don't-care.
//   FIFO: circular, pointers wrap modulo DEPTH, count in 0..DEPTH.
//     mem_we = (count!=0). mem_addr/mem_wdata = entry[head]. pop = mem_we & mem_ready.
//     On pop, head advances at the clock edge.
//   Push, state RUN, memwrite=1:
//     coalesce: if count!=0 and word addr == youngest entry (tail-1) and NOT (count==1 & pop),
//       overwrite that entry's data. Count unchanged. No stall.
//     else if count<DEPTH: write {dataadr,writedata} at tail, tail++.
//     else (full): stall=1, nothing written. The core re-presents the store next cycle.
//     A full buffer does not accept a push in the same cycle as a pop. Stall is combinational
//       on the current count.
//   Simultaneous push+pop: count unchanged. Both pointers advance.
//   Forwarding (combinational): readdata = data of the YOUNGEST entry whose word addr matches
//     dataadr, else mem_rdata. An entry popping this cycle still forwards.
//     A store presented in the same cycle is not forwarded (single-cycle core never reads and writes
//     in the same instruction).
//   FSM:
//     RUN:   flush=1 -> FLUSH.
//     FLUSH: stall=memwrite (stores blocked); pops continue.
//            When count==0, or count==1 & pop: flush_done=1 for that cycle only, -> DONE.
//     DONE:  flush=0 -> RUN. While flush stays high, stay in DONE, stores stall, flush_done=0.
//   Reset mid-operation: all buffered stores are discarded (not written to memory); mem_we drops
//     immediately (async).
//   mem_we/mem_addr/mem_wdata stay stable while mem_ready=0.
// STRUCTURE
//   Shared package mips_pkg: SB_DEPTH default, sb_entry_t {addr[AW-1:0], data[DW-1:0]},
//     sb_state_t enum {SB_RUN, SB_FLUSH, SB_DONE}.
//   One sub-module: sb_fwd_match. Combinational youngest-first priority match over DEPTH entries
//     (inputs: entries, head, count, lookup addr; outputs: hit, data).
//   FIFO storage, pointers and FSM live in mips_store_buffer.
// TESTING
//   1 Reset: hold reset=0 12ns, release. Expect empty=1, mem_we=0, stall=0, readdata==mem_rdata.
//   2 Posted store, mem_ready=0: store 0x00000007 to 0x54. Next cycle empty=0, mem_we=1,
//       mem_addr=0x54, mem_wdata=7. Load 0x54 with mem_rdata=0 returns 7. mem_ready=1 -> empty=1.
//   3 Fill/stall, mem_ready=0: stores to 0x0,0x4,0x8,0xC accepted. Store to 0x10 sees stall=1.
//       Raise mem_ready one cycle: pop 0x0, store 0x10 accepted the following cycle.
//       Drain order is 0x4,0x8,0xC,0x10, with wrap verified.
//   4 Coalesce/forward priority: store 0x54=1, 0x60=2, 0x54=3. Three entries; load 0x54 returns 3.
//       A fourth store 0x54=4 overwrites the tail. Drain writes 0x54=1, 0x60=2, 0x54=4.
//   5 Flush: 2 entries, flush=1, mem_ready=1. Stores stall. flush_done pulses exactly once, in the
//       cycle the last entry pops. flush=0 -> RUN and stores are accepted again.
//   6 Reset mid-drain: 3 entries, mem_ready=0. Assert reset between edges: mem_we=0 and empty=1
//       immediately. After release, no memory write occurs.

Source files
------------

// File: rtl/mips_store_buffer_pkg.sv
// Shared types and defaults for the MIPS posted-write store buffer.
package mips_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;

  // One buffered store: full byte address plus word data.
  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

  typedef enum logic [1:0] {
    SB_RUN,
    SB_FLUSH,
    SB_DONE
  } sb_state_t;

  // Stores and loads are word-only, so the byte offset is ignored in every compare.
  function automatic logic word_match(input logic [SB_AW-1:0] a, input logic [SB_AW-1:0] b);
    return a[SB_AW-1:2] == b[SB_AW-1:2];
  endfunction

endpackage

// File: rtl/mips_store_buffer_if.sv
// Core data port plus memory write port seen by the store buffer.
interface mips_store_buffer_if
  import mips_pkg::*;
#(
  parameter int AW = SB_AW,
  parameter int DW = SB_DW
);

  // core side
  logic          memwrite;
  logic [AW-1:0] dataadr;
  logic [DW-1:0] writedata;
  logic [DW-1:0] readdata;
  logic          stall;
  logic          flush;
  logic          flush_done;
  logic          empty;
  // memory side
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;

  // The store buffer itself.
  modport slave (
    input  memwrite, dataadr, writedata, flush, mem_ready, mem_rdata,
    output readdata, stall, flush_done, empty, mem_we, mem_addr, mem_wdata
  );

  // Core plus memory environment around the buffer.
  modport master (
    output memwrite, dataadr, writedata, flush, mem_ready, mem_rdata,
    input  readdata, stall, flush_done, empty, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mips_store_buffer_fwd_match.sv
// Youngest-first address match over the live entries, used for load forwarding.
module sb_fwd_match
  import mips_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PW    = $clog2(DEPTH)
) (
  input  sb_entry_t        entries [DEPTH],
  input  logic [PW-1:0]    head,
  input  logic [PW:0]      count,
  input  logic [SB_AW-1:0] addr,
  output logic             hit,
  output logic [SB_DW-1:0] data
);

  logic [PW-1:0] idx;

  // Walk oldest to youngest; a later match overrides, so the youngest live match wins.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    hit  = 1'b0;
    data = '0;
    idx  = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (((PW+1)'(i) < count) && word_match(entries[idx].addr, addr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/mips_store_buffer.sv
// Posted-write store buffer: queues core stores, drains them to memory,
// forwards buffered data to loads and supports a flush handshake.
module mips_store_buffer
  import mips_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic                   clk,
  input  logic                   reset,
  mips_store_buffer_if.slave     bus
);

  localparam int         PW   = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  sb_entry_t     entries [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] youngest;
  logic [PW:0]   count;
  sb_state_t     state;

  logic          pop;
  logic          coalesce;
  logic          push;
  logic          flush_last;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic [AW-1:0] lookup;

  assign lookup   = bus.dataadr;
  assign youngest = tail - PW'(1);

  assign bus.empty     = (count == '0);
  assign bus.mem_we    = (count != '0);
  assign bus.mem_addr  = entries[head].addr;
  assign bus.mem_wdata = entries[head].data;
  assign pop           = bus.mem_we & bus.mem_ready;

  // Merge into the youngest entry unless that entry is the one leaving this cycle.
  assign coalesce = (state == SB_RUN) && bus.memwrite && (count != '0) &&
                    word_match(entries[youngest].addr, lookup) &&
                    !((count == (PW+1)'(1)) && pop);

  // A full buffer never takes a push, even alongside a pop.
  assign push = (state == SB_RUN) && bus.memwrite && !coalesce && (count != FULL);

  // Flush completes when the buffer is empty or its last entry drains now.
  assign flush_last     = (count == '0) || ((count == (PW+1)'(1)) && pop);
  assign bus.flush_done = (state == SB_FLUSH) && flush_last;

  // Stores stall on a full buffer while running, and always while flushing.
  always_comb begin
    bus.stall = bus.memwrite;
    if (state == SB_RUN) bus.stall = bus.memwrite && !coalesce && (count == FULL);
  end

  sb_fwd_match #(.DEPTH(DEPTH), .PW(PW)) u_fwd (
    .entries (entries),
    .head    (head),
    .count   (count),
    .addr    (lookup),
    .hit     (fwd_hit),
    .data    (fwd_data)
  );

  assign bus.readdata = fwd_hit ? fwd_data : bus.mem_rdata;

  // Entry storage: appends at tail, coalescing overwrites the youngest data word.
  // NOTE: the entry array is deliberately not reset; count gates every use of it.
  always_ff @(posedge clk) begin
    if (push) entries[tail] <= '{addr: bus.dataadr, data: bus.writedata};
    else if (coalesce) entries[youngest].data <= bus.writedata;
  end

  // Pointers and occupancy; reset discards all buffered stores.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (pop)  head <= head + PW'(1);
      if (push) tail <= tail + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // Flush FSM: RUN -> FLUSH on request, FLUSH -> DONE when drained, DONE -> RUN on release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= SB_RUN;
    end else begin
      case (state)
        SB_RUN:   if (bus.flush) state <= SB_FLUSH;
        SB_FLUSH: if (flush_last) state <= SB_DONE;
        SB_DONE:  if (!bus.flush) state <= SB_RUN;
        default:  state <= SB_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_store_buffer.sv
// Directed bench for mips_store_buffer: reset, posting, fill/stall with wrap,
// coalescing and forwarding, flush handshake, and reset mid-drain.
module tb_mips_store_buffer;

  logic clk;
  logic reset;
  int   total;
  int   passed;

  mips_store_buffer_if #(.AW(32), .DW(32)) bus ();

  mips_store_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs just after the falling edge, then let them settle.
  task automatic drive(input logic mw, input logic [31:0] adr, input logic [31:0] wd,
                       input logic fl, input logic rdy, input logic [31:0] rdata);
    @(negedge clk);
    bus.memwrite  = mw;
    bus.dataadr   = adr;
    bus.writedata = wd;
    bus.flush     = fl;
    bus.mem_ready = rdy;
    bus.mem_rdata = rdata;
    #1;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    reset  = 1'b0;
    bus.memwrite  = 1'b0;
    bus.dataadr   = '0;
    bus.writedata = '0;
    bus.flush     = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'hDEAD_BEEF;

    // 1 reset
    #12 reset = 1'b1;
    #1;
    check("rst_empty", bus.empty, 1);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_stall", bus.stall, 0);
    check("rst_readdata", bus.readdata, 32'hDEAD_BEEF);
    check("rst_flush_done", bus.flush_done, 0);

    // 2 posted store with memory not ready
    drive(1, 32'h54, 32'h7, 0, 0, 0);
    check("post_stall", bus.stall, 0);
    drive(0, 32'h54, 0, 0, 0, 0);
    check("post_empty", bus.empty, 0);
    check("post_mem_we", bus.mem_we, 1);
    check("post_mem_addr", bus.mem_addr, 32'h54);
    check("post_mem_wdata", bus.mem_wdata, 32'h7);
    check("post_fwd", bus.readdata, 32'h7);
    drive(0, 32'h54, 0, 0, 1, 0);
    check("post_pop_fwd", bus.readdata, 32'h7);
    drive(0, 32'h54, 0, 0, 0, 32'h5);
    check("post_drained", bus.empty, 1);
    check("post_no_fwd", bus.readdata, 32'h5);

    // 3 fill, stall on full, pop, accept, drain with pointer wrap
    drive(1, 32'h0, 32'hA0, 0, 0, 0);
    check("fill0_stall", bus.stall, 0);
    drive(1, 32'h4, 32'hA4, 0, 0, 0);
    check("fill1_stall", bus.stall, 0);
    drive(1, 32'h8, 32'hA8, 0, 0, 0);
    check("fill2_stall", bus.stall, 0);
    drive(1, 32'hC, 32'hAC, 0, 0, 0);
    check("fill3_stall", bus.stall, 0);
    drive(1, 32'h10, 32'hB0, 0, 0, 0);
    check("full_stall", bus.stall, 1);
    drive(1, 32'h10, 32'hB0, 0, 1, 0);
    check("full_pop_stall", bus.stall, 1);
    check("full_pop_addr", bus.mem_addr, 32'h0);
    check("full_pop_data", bus.mem_wdata, 32'hA0);
    drive(1, 32'h10, 32'hB0, 0, 0, 0);
    check("after_pop_stall", bus.stall, 0);
    drive(0, 0, 0, 0, 1, 0);
    check("drain0_addr", bus.mem_addr, 32'h4);
    check("drain0_data", bus.mem_wdata, 32'hA4);
    drive(0, 0, 0, 0, 1, 0);
    check("drain1_addr", bus.mem_addr, 32'h8);
    drive(0, 0, 0, 0, 1, 0);
    check("drain2_addr", bus.mem_addr, 32'hC);
    drive(0, 0, 0, 0, 1, 0);
    check("drain3_addr", bus.mem_addr, 32'h10);
    check("drain3_data", bus.mem_wdata, 32'hB0);
    drive(0, 0, 0, 0, 0, 0);
    check("drain_empty", bus.empty, 1);

    // 4 coalescing and youngest-first forwarding
    drive(1, 32'h54, 32'h1, 0, 0, 0);
    drive(1, 32'h60, 32'h2, 0, 0, 0);
    drive(1, 32'h54, 32'h3, 0, 0, 0);
    check("co_no_stall", bus.stall, 0);
    drive(0, 32'h54, 0, 0, 0, 32'h99);
    check("co_fwd_young", bus.readdata, 32'h3);
    drive(0, 32'h62, 0, 0, 0, 32'h99);
    check("co_fwd_60", bus.readdata, 32'h2);
    drive(0, 32'h58, 0, 0, 0, 32'h99);
    check("co_fwd_miss", bus.readdata, 32'h99);
    drive(1, 32'h54, 32'h4, 0, 0, 0);
    check("co_merge_stall", bus.stall, 0);
    drive(0, 32'h54, 0, 0, 1, 0);
    check("co_fwd_merged", bus.readdata, 32'h4);
    check("co_d0_addr", bus.mem_addr, 32'h54);
    check("co_d0_data", bus.mem_wdata, 32'h1);
    drive(0, 0, 0, 0, 1, 0);
    check("co_d1_addr", bus.mem_addr, 32'h60);
    check("co_d1_data", bus.mem_wdata, 32'h2);
    drive(0, 0, 0, 0, 1, 0);
    check("co_d2_addr", bus.mem_addr, 32'h54);
    check("co_d2_data", bus.mem_wdata, 32'h4);
    drive(0, 0, 0, 0, 0, 0);
    check("co_empty", bus.empty, 1);

    // 5 flush handshake
    drive(1, 32'h100, 32'h11, 0, 0, 0);
    drive(1, 32'h104, 32'h22, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    check("fl_req_done", bus.flush_done, 0);
    drive(1, 32'h108, 32'h33, 1, 1, 0);
    check("fl_stall0", bus.stall, 1);
    check("fl_done0", bus.flush_done, 0);
    check("fl_addr0", bus.mem_addr, 32'h100);
    drive(1, 32'h108, 32'h33, 1, 1, 0);
    check("fl_stall1", bus.stall, 1);
    check("fl_done1", bus.flush_done, 1);
    check("fl_addr1", bus.mem_addr, 32'h104);
    drive(1, 32'h108, 32'h33, 1, 1, 0);
    check("fl_hold_stall", bus.stall, 1);
    check("fl_hold_done", bus.flush_done, 0);
    check("fl_hold_empty", bus.empty, 1);
    drive(0, 0, 0, 0, 0, 0);
    check("fl_rel_done", bus.flush_done, 0);
    drive(1, 32'h108, 32'h33, 0, 0, 0);
    check("fl_run_stall", bus.stall, 0);
    drive(0, 0, 0, 0, 0, 0);
    check("fl_run_empty", bus.empty, 0);
    check("fl_run_addr", bus.mem_addr, 32'h108);

    // 6 reset in the middle of a drain
    drive(1, 32'h200, 32'h1, 0, 0, 0);
    drive(1, 32'h204, 32'h2, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    check("mr_pre_we", bus.mem_we, 1);
    #2 reset = 1'b0;
    #1;
    check("mr_we_async", bus.mem_we, 0);
    check("mr_empty_async", bus.empty, 1);
    #1 reset = 1'b1;
    drive(0, 0, 0, 0, 1, 0);
    check("mr_post0_we", bus.mem_we, 0);
    drive(0, 0, 0, 0, 1, 0);
    check("mr_post1_we", bus.mem_we, 0);
    drive(0, 0, 0, 0, 1, 0);
    check("mr_post2_we", bus.mem_we, 0);
    check("mr_post_stall", bus.stall, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
